// File: rtl/shift_mon_pkg.sv
// Shared types, limits and adjacency helpers for the LED shift-bus monitor.
package shift_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int unsigned STEP_CNT_W = 16;
    localparam int unsigned REV_CNT_W  = 8;
    localparam logic [STEP_CNT_W-1:0] STEP_CNT_MAX = '1;
    localparam logic [REV_CNT_W-1:0]  REV_CNT_MAX  = '1;

    // Left step means index+1 modulo width; width is a power of two.
    function automatic logic is_left_step(input int unsigned prev_idx,
                                          input int unsigned new_idx,
                                          input int unsigned width);
        return ((prev_idx + 1) & (width - 1)) == new_idx;
    endfunction

    function automatic logic is_adjacent(input int unsigned prev_idx,
                                         input int unsigned new_idx,
                                         input int unsigned width);
        return is_left_step(prev_idx, new_idx, width) || is_left_step(new_idx, prev_idx, width);
    endfunction

endpackage

// File: rtl/shift_onehot_dec.sv
// Combinational one-hot decoder: lit-bit index plus an exactly-one-bit-set flag.
module shift_onehot_dec #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         vec_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     is_onehot_o
);

    localparam int unsigned POS_W = $clog2(WIDTH);

    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_o = POS_W'(i);
            end
        end
        is_onehot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/shift_pattern_monitor.sv
// Decodes the walking one-hot LED bus into position, direction and step events,
// and flags illegal patterns, illegal jumps and stalls.
module shift_pattern_monitor
    import shift_mon_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned RESET_POS    = 0,
    parameter int unsigned STALL_CYCLES = 2_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         q_in,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     dir,
    output logic                     valid,
    output logic                     step,
    output logic                     resync,
    output logic                     rev,
    output logic                     err,
    output logic                     stall,
    output logic [STEP_CNT_W-1:0]    step_cnt,
    output logic [REV_CNT_W-1:0]     rev_cnt
);

    localparam int unsigned POS_W   = $clog2(WIDTH);
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      q_s_q, q_prev_q;
    logic [POS_W-1:0]      prev_idx_q;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  dir_q, dir_d;
    logic                  valid_q, valid_d;
    logic                  step_q, step_d;
    logic                  resync_q, resync_d;
    logic                  rev_q, rev_d;
    logic                  err_q, err_d;
    logic                  stall_q, stall_d;
    logic                  hist_q, hist_d;
    logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [REV_CNT_W-1:0]  rev_cnt_q, rev_cnt_d;

    logic [POS_W-1:0] cur_idx;
    logic             cur_onehot;
    logic             changed, adjacent, left;

    shift_onehot_dec #(.WIDTH(WIDTH)) u_dec (
        .vec_i       (q_s_q),
        .idx_o       (cur_idx),
        .is_onehot_o (cur_onehot)
    );

    // q_prev is always the last accepted pattern while tracking, so its index is trustworthy.
    assign changed  = (q_s_q != q_prev_q);
    assign adjacent = is_adjacent(32'(prev_idx_q), 32'(cur_idx), WIDTH);
    assign left     = is_left_step(32'(prev_idx_q), 32'(cur_idx), WIDTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            q_s_q       <= '0;
            q_prev_q    <= '0;
            prev_idx_q  <= '0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            valid_q     <= 1'b0;
            step_q      <= 1'b0;
            resync_q    <= 1'b0;
            rev_q       <= 1'b0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            hist_q      <= 1'b0;
            stall_cnt_q <= '0;
            step_cnt_q  <= '0;
            rev_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            q_s_q       <= q_in;
            q_prev_q    <= q_s_q;
            prev_idx_q  <= cur_idx;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            valid_q     <= valid_d;
            step_q      <= step_d;
            resync_q    <= resync_d;
            rev_q       <= rev_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            hist_q      <= hist_d;
            stall_cnt_q <= stall_cnt_d;
            step_cnt_q  <= step_cnt_d;
            rev_cnt_q   <= rev_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        valid_d     = valid_q;
        step_d      = 1'b0;
        resync_d    = 1'b0;
        rev_d       = 1'b0;
        err_d       = err_q;
        stall_d     = stall_q;
        hist_d      = hist_q;
        stall_cnt_d = stall_cnt_q;
        step_cnt_d  = step_cnt_q;
        rev_cnt_d   = rev_cnt_q;

        if (clr) begin
            state_d     = ST_IDLE;
            valid_d     = 1'b0;
            err_d       = 1'b0;
            stall_d     = 1'b0;
            hist_d      = 1'b0;
            stall_cnt_d = '0;
            step_cnt_d  = '0;
            rev_cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    stall_cnt_d = '0;
                    stall_d     = 1'b0;
                    hist_d      = 1'b0;
                    if (cur_onehot) begin
                        pos_d   = cur_idx;
                        valid_d = 1'b1;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (!changed) begin
                        stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + 1'b1;
                        stall_d     = (stall_cnt_d == STALL_MAX);
                    end else if (cur_onehot && adjacent) begin
                        pos_d       = cur_idx;
                        dir_d       = left;
                        step_d      = 1'b1;
                        hist_d      = 1'b1;
                        stall_cnt_d = '0;
                        stall_d     = 1'b0;
                        if (step_cnt_q != STEP_CNT_MAX) step_cnt_d = step_cnt_q + 1'b1;
                        if (hist_q && (left != dir_q)) begin
                            rev_d = 1'b1;
                            if (rev_cnt_q != REV_CNT_MAX) rev_cnt_d = rev_cnt_q + 1'b1;
                        end
                    end else if (cur_onehot && (cur_idx == POS_W'(RESET_POS))) begin
                        pos_d       = cur_idx;
                        resync_d    = 1'b1;
                        hist_d      = 1'b0;
                        stall_cnt_d = '0;
                        stall_d     = 1'b0;
                    end else begin
                        state_d = ST_FAULT;
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign pos      = pos_q;
    assign dir      = dir_q;
    assign valid    = valid_q;
    assign step     = step_q;
    assign resync   = resync_q;
    assign rev      = rev_q;
    assign err      = err_q;
    assign stall    = stall_q;
    assign step_cnt = step_cnt_q;
    assign rev_cnt  = rev_cnt_q;

endmodule

// File: tb/tb_shift_pattern_monitor.sv
// Bench for shift_pattern_monitor: directed literal checks plus random walks
// compared every cycle against a behavioural model.
module tb_shift_pattern_monitor;

    localparam int unsigned W  = 8;
    localparam int unsigned RP = 0;
    localparam int unsigned SC = 20;

    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr   = 1'b0;
    logic [7:0] q_in  = 8'h00;

    logic [2:0]  pos;
    logic        dir, valid, step, resync, rev, err, stall;
    logic [15:0] step_cnt;
    logic [7:0]  rev_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        chk_en  = 1'b0;

    always #5 clk = ~clk;

    shift_pattern_monitor #(
        .WIDTH        (W),
        .RESET_POS    (RP),
        .STALL_CYCLES (SC)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .q_in     (q_in),
        .clr      (clr),
        .pos      (pos),
        .dir      (dir),
        .valid    (valid),
        .step     (step),
        .resync   (resync),
        .rev      (rev),
        .err      (err),
        .stall    (stall),
        .step_cnt (step_cnt),
        .rev_cnt  (rev_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the bus value seen one edge ago is judged against the one before it.
    logic [7:0] m_s, m_prev;
    int         m_mode, m_pos, m_same, m_step_cnt, m_rev_cnt;
    logic       m_dir, m_valid, m_step, m_resync, m_rev, m_err, m_stall, m_have_dir;

    task automatic model_reset();
        m_s = 8'h00; m_prev = 8'h00;
        m_mode = M_IDLE; m_pos = 0; m_same = 0; m_step_cnt = 0; m_rev_cnt = 0;
        m_dir = 0; m_valid = 0; m_step = 0; m_resync = 0; m_rev = 0;
        m_err = 0; m_stall = 0; m_have_dir = 0;
    endtask

    task automatic model_fault();
        m_mode = M_FAULT; m_err = 1; m_valid = 0;
    endtask

    task automatic model_edge(input logic [7:0] bus, input logic c);
        logic [7:0] cur, prv;
        int ci, pi;
        logic go_left;
        cur = m_s; prv = m_prev;
        m_prev = m_s; m_s = bus;
        m_step = 0; m_resync = 0; m_rev = 0;
        if (c) begin
            m_mode = M_IDLE; m_valid = 0; m_err = 0; m_stall = 0; m_same = 0;
            m_step_cnt = 0; m_rev_cnt = 0; m_have_dir = 0;
        end else if (m_mode == M_IDLE) begin
            if ($countones(cur) == 1) begin
                m_pos = $clog2(cur); m_valid = 1; m_mode = M_TRACK;
                m_same = 0; m_have_dir = 0;
            end
        end else if (m_mode == M_TRACK) begin
            if (cur == prv) begin
                if (m_same < int'(SC)) m_same++;
                m_stall = (m_same >= int'(SC));
            end else if ($countones(cur) == 1) begin
                ci = $clog2(cur);
                pi = $clog2(prv);
                if (ci == (pi + 1) % int'(W) || ci == (pi + int'(W) - 1) % int'(W)) begin
                    go_left = (ci == (pi + 1) % int'(W));
                    m_step = 1;
                    if (m_step_cnt < 65535) m_step_cnt++;
                    if (m_have_dir && go_left != m_dir) begin
                        m_rev = 1;
                        if (m_rev_cnt < 255) m_rev_cnt++;
                    end
                    m_dir = go_left; m_have_dir = 1; m_pos = ci; m_same = 0; m_stall = 0;
                end else if (ci == int'(RP)) begin
                    m_resync = 1; m_pos = int'(RP); m_have_dir = 0; m_same = 0; m_stall = 0;
                end else begin
                    model_fault();
                end
            end else begin
                model_fault();
            end
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge(q_in, clr);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_pos",      32'(pos),      32'(m_pos));
            chk("cmp_dir",      32'(dir),      32'(m_dir));
            chk("cmp_valid",    32'(valid),    32'(m_valid));
            chk("cmp_step",     32'(step),     32'(m_step));
            chk("cmp_resync",   32'(resync),   32'(m_resync));
            chk("cmp_rev",      32'(rev),      32'(m_rev));
            chk("cmp_err",      32'(err),      32'(m_err));
            chk("cmp_stall",    32'(stall),    32'(m_stall));
            chk("cmp_step_cnt", 32'(step_cnt), 32'(m_step_cnt));
            chk("cmp_rev_cnt",  32'(rev_cnt),  32'(m_rev_cnt));
        end
    end

    task automatic drive(input logic [7:0] v, input int n);
        q_in = v;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_clr(input logic [7:0] v);
        q_in = v;
        clr  = 1'b1;
        @(negedge clk);
        clr  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pos"},      32'(pos),      32'd0);
        chk({tag, "_dir"},      32'(dir),      32'd0);
        chk({tag, "_valid"},    32'(valid),    32'd0);
        chk({tag, "_step"},     32'(step),     32'd0);
        chk({tag, "_resync"},   32'(resync),   32'd0);
        chk({tag, "_rev"},      32'(rev),      32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_stall"},    32'(stall),    32'd0);
        chk({tag, "_step_cnt"}, 32'(step_cnt), 32'd0);
        chk({tag, "_rev_cnt"},  32'(rev_cnt),  32'd0);
    endtask

    initial begin
        logic [7:0] v;
        int nsteps, nrevs, first_stall, saved_cnt, gen_pos, r;

        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        drive(8'h01, 2);
        chk("lock_valid", 32'(valid), 32'd1);
        chk("lock_pos",   32'(pos),   32'd0);
        chk("lock_step",  32'(step),  32'd0);
        chk("lock_err",   32'(err),   32'd0);

        // Full walk around the ring, wrapping 0x80 -> 0x01.
        nsteps = 0; nrevs = 0; v = 8'h01;
        for (int i = 0; i < 8; i++) begin
            v = {v[6:0], v[7]};
            drive(v, 1);
            nsteps += int'(step); nrevs += int'(rev);
        end
        drive(v, 1);
        nsteps += int'(step); nrevs += int'(rev);
        chk("walk_steps",    32'(nsteps),   32'd8);
        chk("walk_revs",     32'(nrevs),    32'd0);
        chk("walk_dir",      32'(dir),      32'd1);
        chk("walk_pos",      32'(pos),      32'd0);
        chk("walk_step_cnt", 32'(step_cnt), 32'd8);
        chk("walk_err",      32'(err),      32'd0);

        drive(8'h02, 1); drive(8'h04, 1); drive(8'h02, 2);
        chk("rev1_pulse", 32'(rev),     32'd1);
        chk("rev1_dir",   32'(dir),     32'd0);
        chk("rev1_pos",   32'(pos),     32'd1);
        chk("rev1_cnt",   32'(rev_cnt), 32'd1);
        drive(8'h04, 2);
        chk("rev2_pulse", 32'(rev),      32'd1);
        chk("rev2_cnt",   32'(rev_cnt),  32'd2);
        chk("rev2_steps", 32'(step_cnt), 32'd12);

        drive(8'h08, 1); drive(8'h10, 1); drive(8'h20, 2);
        chk("pre_resync_pos", 32'(pos), 32'd5);
        saved_cnt = int'(step_cnt);
        drive(8'h01, 2);
        chk("resync_pulse",    32'(resync),   32'd1);
        chk("resync_pos",      32'(pos),      32'd0);
        chk("resync_err",      32'(err),      32'd0);
        chk("resync_step_cnt", 32'(step_cnt), 32'(saved_cnt));
        drive(8'h80, 2);
        chk("post_resync_step", 32'(step), 32'd1);
        chk("post_resync_rev",  32'(rev),  32'd0);
        chk("post_resync_dir",  32'(dir),  32'd0);

        drive(8'h18, 2);
        chk("multihot_err",   32'(err),   32'd1);
        chk("multihot_valid", 32'(valid), 32'd0);
        chk("multihot_pos",   32'(pos),   32'd7);
        drive(8'h01, 2); drive(8'h02, 2);
        chk("sticky_err",   32'(err),   32'd1);
        chk("sticky_valid", 32'(valid), 32'd0);
        pulse_clr(8'h01);
        chk("clr_err",      32'(err),      32'd0);
        chk("clr_valid",    32'(valid),    32'd0);
        chk("clr_step_cnt", 32'(step_cnt), 32'd0);
        chk("clr_rev_cnt",  32'(rev_cnt),  32'd0);
        drive(8'h01, 1);
        chk("relock_valid", 32'(valid), 32'd1);
        chk("relock_pos",   32'(pos),   32'd0);

        drive(8'h00, 2);
        chk("zero_err",   32'(err),   32'd1);
        chk("zero_valid", 32'(valid), 32'd0);
        pulse_clr(8'h01);
        drive(8'h01, 1);

        drive(8'h02, 1); drive(8'h04, 1); drive(8'h08, 1); drive(8'h10, 2);
        chk("stall_pre_step", 32'(step), 32'd1);
        first_stall = -1;
        for (int i = 1; i <= 25; i++) begin
            drive(8'h10, 1);
            if (stall && first_stall < 0) first_stall = i;
        end
        chk("stall_first_cycle", 32'(first_stall), 32'd20);
        chk("stall_held",        32'(stall),       32'd1);
        drive(8'h20, 2);
        chk("stall_cleared", 32'(stall), 32'd0);
        chk("stall_step",    32'(step),  32'd1);

        drive(8'h40, 1); drive(8'h80, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Random walks with holds, resync jumps, illegal values and clears.
        drive(8'h01, 2);
        gen_pos = 0;
        for (int it = 0; it < 3000; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                gen_pos = (gen_pos + 1) % 8;
                drive(8'h01 << gen_pos, 1);
            end else if (r < 80) begin
                gen_pos = (gen_pos + 7) % 8;
                drive(8'h01 << gen_pos, 1);
            end else if (r < 86) begin
                drive(8'h01 << gen_pos, int'($urandom_range(1, 25)));
            end else if (r < 90) begin
                gen_pos = int'(RP);
                drive(8'h01 << gen_pos, 1);
            end else if (r < 94) begin
                drive(8'($urandom_range(0, 255)), 1);
            end else begin
                pulse_clr(8'h01 << gen_pos);
            end
        end
        drive(8'h01 << gen_pos, 3);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
